// File: rtl/io_bridge_if.sv
// CPU data-bus bundle between the core's MEM stage and the io_bridge.
// No handshake: every access completes in the cycle it is presented.
interface io_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (
    output Bus_addr,
    output Bus_wen,
    output Bus_wdata,
    input  Bus_rdata
  );

  modport slave (
    input  Bus_addr,
    input  Bus_wen,
    input  Bus_wdata,
    output Bus_rdata
  );
endinterface

// File: rtl/io_bridge.sv
// Data-bus bridge: routes CPU accesses to data RAM or on-board peripheral registers,
// and owns the seven-segment scanner, the prescaled timer and the input synchronisers.
module io_bridge #(
  parameter int unsigned SCAN_DIV  = 20000,
  parameter int unsigned TIMER_DIV = 25000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  io_bridge_if.slave  bus,
  output logic [15:0] dram_addr,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned TIMER_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TIMER_W-1:0] TIMER_TC = TIMER_W'(TIMER_DIV - 1);

  localparam logic [11:0] OFF_DIG   = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  // Active-low hex glyphs, segment order {dp,g,f,e,d,c,b,a}; dp kept dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  logic [23:0]        led_q,    led_d;
  logic [31:0]        dig_q,    dig_d;
  logic [31:0]        timer_q,  timer_d;
  logic [TIMER_W-1:0] presc_q,  presc_d;
  logic [SCAN_W-1:0]  scan_q,   scan_d;
  logic [2:0]         idx_q,    idx_d;
  logic [23:0]        sw_s1_q,  sw_s2_q;
  logic [4:0]         btn_s1_q, btn_s2_q;

  logic        is_io_s;
  logic [11:0] off_s;
  logic        wr_io_s;

  // Address decode and combinational read mux.
  always_comb begin
    is_io_s = (bus.Bus_addr[31:12] == 20'hFFFFF);
    off_s   = bus.Bus_addr[11:0];
    wr_io_s = bus.Bus_wen & is_io_s;
    if (!is_io_s) begin
      bus.Bus_rdata = dram_rdata;
    end else begin
      case (off_s)
        OFF_DIG:   bus.Bus_rdata = dig_q;
        OFF_TIMER: bus.Bus_rdata = timer_q;
        OFF_LED:   bus.Bus_rdata = {8'h00, led_q};
        OFF_SW:    bus.Bus_rdata = {8'h00, sw_s2_q};
        OFF_BTN:   bus.Bus_rdata = {27'h0000000, btn_s2_q};
        default:   bus.Bus_rdata = 32'h0000_0000;
      endcase
    end
  end

  // Next-state for registers, timer and scanner; a TIMER write beats a same-cycle tick.
  always_comb begin
    led_d = led_q;
    dig_d = dig_q;
    if (wr_io_s && (off_s == OFF_LED)) begin
      led_d = bus.Bus_wdata[23:0];
    end else begin
      led_d = led_q;
    end
    if (wr_io_s && (off_s == OFF_DIG)) begin
      dig_d = bus.Bus_wdata;
    end else begin
      dig_d = dig_q;
    end

    if (wr_io_s && (off_s == OFF_TIMER)) begin
      timer_d = bus.Bus_wdata;
      presc_d = '0;
    end else if (presc_q == TIMER_TC) begin
      timer_d = timer_q + 32'd1;
      presc_d = '0;
    end else begin
      timer_d = timer_q;
      presc_d = presc_q + TIMER_W'(1);
    end

    if (scan_q == SCAN_TC) begin
      scan_d = '0;
      idx_d  = idx_q + 3'd1;
    end else begin
      scan_d = scan_q + SCAN_W'(1);
      idx_d  = idx_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      led_q    <= 24'h000000;
      dig_q    <= 32'h0000_0000;
      timer_q  <= 32'h0000_0000;
      presc_q  <= '0;
      scan_q   <= '0;
      idx_q    <= 3'd0;
      sw_s1_q  <= 24'h000000;
      sw_s2_q  <= 24'h000000;
      btn_s1_q <= 5'h00;
      btn_s2_q <= 5'h00;
    end else begin
      led_q    <= led_d;
      dig_q    <= dig_d;
      timer_q  <= timer_d;
      presc_q  <= presc_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Outputs are pure decodes of registered state, so reset forces FE/C0 at once.
  always_comb begin
    dram_addr  = bus.Bus_addr[17:2];
    dram_wen   = bus.Bus_wen & ~is_io_s;
    dram_wdata = bus.Bus_wdata;
    led        = led_q;
    dig_en     = ~(8'b0000_0001 << idx_q);
    dig_seg    = seg_decode(dig_q[{idx_q, 2'b00} +: 4]);
  end

endmodule

// File: doc/io_bridge.md
# io_bridge

Memory-mapped bus bridge sitting directly downstream of the CPU core's data-bus port (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata). It decodes each data access to either the data RAM or one of the on-board peripheral registers: LEDs, switches, buttons, eight-digit seven-segment display and a prescaled timer. It also owns the display multiplexing scanner and the timer counter.

## Interface
Parameters:
- SCAN_DIV, 20000, cpu_clk cycles each display digit stays lit; must be ≥ 1.
- TIMER_DIV, 25000, cpu_clk cycles per timer increment; must be ≥ 1.

Ports:
- cpu_clk  in  1  single clock for all state.
- cpu_rst  in  1  asynchronous, active-low reset.
- Bus_addr  in  32  byte address from the CPU MEM stage.
- Bus_wen  in  1  write enable; sampled on the rising edge.
- Bus_wdata  in  32  write data.
- Bus_rdata  out  32  read data; combinational from Bus_addr.
- dram_addr  out  16  word address, Bus_addr[17:2].
- dram_wen  out  1  data RAM write enable.
- dram_wdata  out  32  Bus_wdata passthrough.
- dram_rdata  in  32  data RAM asynchronous read data.
- sw  in  24  switches; asynchronous inputs.
- btn  in  5  buttons; asynchronous inputs.
- led  out  24  LED outputs; active-high.
- dig_en  out  8  digit enables; active-low, one-hot.
- dig_seg  out  8  segments {dp,g,f,e,d,c,b,a}; active-low.

## Operation
- is_io = (Bus_addr[31:12] == 20'hFFFFF). All other addresses go to RAM.
- dram_wen = Bus_wen & ~is_io. Bus_rdata = dram_rdata when ~is_io.
- IO map (Bus_addr[11:0]):
  - 0x000 DIG, R/W: 32-bit display value.
  - 0x020 TIMER, R/W.
  - 0x060 LED, R/W: bits [23:0]; reads zero-extend.
  - 0x070 SW, R: synchronised sw, zero-extended.
  - 0x078 BTN, R: synchronised btn, zero-extended.
- Unmapped IO offsets read 0. Writes to them have no effect, and RAM is never written.
- Writes to SW/BTN are ignored.
- sw and btn each pass through a 2-flop synchroniser. Reads return the second flop.
- Timer logic:
  - A prescaler counts 0..TIMER_DIV-1. At terminal count it returns to 0 and TIMER increments; TIMER wraps 0xFFFFFFFF → 0.
  - A TIMER write loads Bus_wdata and clears the prescaler. The write wins over a same-cycle increment.
- Display scanner:
  - scan_cnt counts 0..SCAN_DIV-1. At terminal count it returns to 0 and digit index idx advances 0→1→…→7→0.
  - dig_en = ~(8'b1 << idx).
  - dig_seg = active-low hex decode of DIG[4*idx+3:4*idx], with dp always off (bit 7 = 1).
  - Decode: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Reset (cpu_rst low) is asynchronous and may occur mid-operation. It clears:
  - LED, DIG, TIMER, prescaler, scan_cnt, idx and the synchronisers, all to 0.
  - Outputs during reset: led=0, dig_en=8'hFE, dig_seg=8'hC0.

## Timing
- RAM and IO reads are combinational, zero added latency. Bus_rdata is valid in the same cycle as Bus_addr.
- Register writes commit on the rising edge with Bus_wen=1. The new value is readable and visible on led/dig_seg from the next cycle.
- A write to DIG of the currently displayed nibble changes dig_seg one cycle after the edge.
- sw/btn changes are visible on Bus_rdata 2 cycles after they settle.
- TIMER increments exactly every TIMER_DIV cycles after reset or after a TIMER write.
- idx advances every SCAN_DIV cycles. SCAN_DIV=1 advances idx every cycle.
- The bridge never stalls the CPU. There is no handshake: every access completes in one cycle.

## Test plan
- RAM path: write 0x12345678 to 0x00000010 → dram_wen=1, dram_addr=4; IO registers unchanged. Read 0x00000010 returns dram_rdata.
- LED/unmapped: write 0xFFABCDEF to 0xFFFFF060 → led=0xABCDEF next cycle, dram_wen=0. Write to 0xFFFFF100 → no change; reading it returns 0.
- Switch sync: set sw=0x00F00F → reading 0xFFFFF070 returns 0 for 2 cycles, then 0x00F00F. Same check for btn=5'h15 at 0xFFFFF078.
- Timer (TIMER_DIV=4): after reset, read 0xFFFFF020 = 3 at cycle 12. Write 0xFFFFFFFF → wraps to 0 four cycles later. A write coinciding with terminal count loads the written value.
- Display (SCAN_DIV=2): write DIG=0x89ABCDEF → dig_en sequence FE,FD,…,7F with 2 cycles each. dig_seg sequence 8E,86,A1,C6,83,88,90,80, then wraps to digit 0.
- Async reset mid-scan with TIMER≠0: drop cpu_rst between clock edges → led=0, TIMER=0, dig_en=FE, dig_seg=C0 immediately. Operation resumes from idx 0 after release.
